// File: rtl/apu_dac_multi.sv
// ============================================================================
// Module   : apu_dac_multi
// Purpose  : Double-buffered multi-channel 1-bit audio DAC (PWM or 1st-order PDM)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module apu_dac_multi #(
  parameter int CHANNELS = 2,
  parameter int WIDTH    = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        mode,
  input  logic [CHANNELS*WIDTH-1:0]   sample_data,
  input  logic                        sample_valid,
  output logic                        sample_ready,
  output logic [CHANNELS-1:0]         dac_out,
  output logic                        frame_tick,
  output logic                        underrun
);

  localparam logic [WIDTH-1:0] c_cnt_last = '1;

  logic [WIDTH-1:0]                cnt_q, cnt_d;
  logic [CHANNELS-1:0][WIDTH-1:0]  shadow_q, shadow_d;
  logic                            shadow_full_q, shadow_full_d;
  logic [CHANNELS-1:0][WIDTH-1:0]  active_q, active_d;
  logic                            mode_q, mode_d;
  logic [CHANNELS-1:0][WIDTH-1:0]  acc_q, acc_d;
  logic [CHANNELS-1:0]             dac_q, dac_d;
  logic                            frame_tick_q, frame_tick_d;
  logic                            underrun_q, underrun_d;

  logic                            boundary;
  logic                            accept;
  logic                            mode_change;
  logic [CHANNELS-1:0][WIDTH:0]    sum;

  // Carry out of the accumulator sum is the sigma-delta output bit.
  for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
    assign sum[n] = {1'b0, acc_q[n]} + {1'b0, active_q[n]};
  end

  assign boundary    = (cnt_q == c_cnt_last);
  assign accept      = sample_valid && !shadow_full_q;
  assign mode_change = boundary && (mode != mode_q);

  always_comb begin
    cnt_d         = cnt_q + 1'b1;
    shadow_d      = shadow_q;
    shadow_full_d = shadow_full_q;
    active_d      = active_q;
    mode_d        = mode_q;
    acc_d         = acc_q;
    dac_d         = dac_q;
    frame_tick_d  = boundary;
    underrun_d    = boundary && !shadow_full_q;

    // A boundary accept lands in the shadow; it never bypasses to active.
    if (accept) begin
      shadow_d      = sample_data;
      shadow_full_d = 1'b1;
    end

    if (boundary) begin
      mode_d = mode;
      if (shadow_full_q) begin
        active_d      = shadow_q;
        shadow_full_d = 1'b0;
      end
    end

    for (int n = 0; n < CHANNELS; n++) begin
      if (mode_q) begin
        dac_d[n] = sum[n][WIDTH];
        acc_d[n] = sum[n][WIDTH-1:0];
      end else begin
        dac_d[n] = (cnt_q < active_q[n]);
      end
      if (mode_change) begin
        acc_d[n] = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q         <= '0;
      shadow_q      <= '0;
      shadow_full_q <= 1'b0;
      active_q      <= '0;
      mode_q        <= 1'b0;
      acc_q         <= '0;
      dac_q         <= '0;
      frame_tick_q  <= 1'b0;
      underrun_q    <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      shadow_q      <= shadow_d;
      shadow_full_q <= shadow_full_d;
      active_q      <= active_d;
      mode_q        <= mode_d;
      acc_q         <= acc_d;
      dac_q         <= dac_d;
      frame_tick_q  <= frame_tick_d;
      underrun_q    <= underrun_d;
    end
  end

  assign sample_ready = !shadow_full_q;
  assign dac_out      = dac_q;
  assign frame_tick   = frame_tick_q;
  assign underrun     = underrun_q;

endmodule

`default_nettype wire

// File: tb/tb_apu_dac_multi.sv
// ============================================================================
// Module   : tb_apu_dac_multi
// Purpose  : Scoreboard bench for apu_dac_multi (CHANNELS=2, WIDTH=8)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_apu_dac_multi;

  localparam int CH    = 2;
  localparam int W     = 8;
  localparam int FRAME = 256;

  typedef logic [CH-1:0][W-1:0] vec_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          mode = 1'b0;
  logic [CH*W-1:0] sample_data = '0;
  logic          sample_valid = 1'b0;
  logic          sample_ready;
  logic [CH-1:0] dac_out;
  logic          frame_tick;
  logic          underrun;

  apu_dac_multi #(.CHANNELS(CH), .WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .mode         (mode),
    .sample_data  (sample_data),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .dac_out      (dac_out),
    .frame_tick   (frame_tick),
    .underrun     (underrun)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Reference frame position and scoreboard of accepted-but-not-yet-active samples.
  int   tb_cnt = 0;
  vec_t sb[$];
  vec_t cur_exp = '0;
  vec_t win_exp = '0;
  int   ones[CH];
  int   win_ones[CH];
  int   n_win = 0, n_tick = 0, n_urun = 0, n_acc = 0;
  int   tick_err = 0, urun_err = 0, ready_err = 0;

  task automatic tick();
    logic r, b, acc_pre, exp_urun;
    vec_t d;
    r       = rst;
    b       = (tb_cnt == FRAME-1);
    acc_pre = sample_valid && (sb.size() == 0);
    d       = sample_data;
    @(posedge clk);
    #1;
    if (r) begin
      tb_cnt  = 0;
      sb.delete();
      cur_exp = '0;
      for (int c = 0; c < CH; c++) ones[c] = 0;
    end else begin
      tb_cnt = (tb_cnt + 1) % FRAME;
      for (int c = 0; c < CH; c++) ones[c] += int'(dac_out[c]);
      exp_urun = b && (sb.size() == 0);
      if (tb_cnt == 0) begin
        win_ones = ones;
        win_exp  = cur_exp;
        for (int c = 0; c < CH; c++) ones[c] = 0;
        n_win++;
      end
      if (b && sb.size() != 0) cur_exp = sb.pop_front();
      if (acc_pre) begin
        sb.push_back(d);
        n_acc++;
      end
      if (frame_tick !== b) tick_err++;
      if (underrun !== exp_urun) urun_err++;
      n_tick += int'(frame_tick);
      n_urun += int'(underrun);
    end
    if (sample_ready !== (sb.size() == 0)) ready_err++;
  endtask

  task automatic run_to(input int target);
    for (int i = 0; i < FRAME + 1 && tb_cnt != target; i++) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; sample_valid = 1'b0; mode = 1'b0;
    tick(); tick();
    n_vec++; if (dac_out !== 2'b00) begin n_bad++; $display("FAIL rst_dac: got %b want 00", dac_out); end
    n_vec++; if (frame_tick !== 1'b0) begin n_bad++; $display("FAIL rst_tick: got %b want 0", frame_tick); end
    n_vec++; if (underrun !== 1'b0) begin n_bad++; $display("FAIL rst_underrun: got %b want 0", underrun); end
    n_vec++; if (sample_ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready: got %b want 1", sample_ready); end
    rst = 1'b0;
    tick_err = 0; urun_err = 0; ready_err = 0; n_tick = 0; n_urun = 0;
  endtask

  task automatic test_idle();
    int z_err = 0;
    for (int i = 0; i < 3*FRAME; i++) begin
      tick();
      if (dac_out !== 2'b00) z_err++;
    end
    n_vec++; if (z_err != 0) begin n_bad++; $display("FAIL idle_dac: got %0d nonzero cycles want 0", z_err); end
    n_vec++; if (n_tick != 3) begin n_bad++; $display("FAIL idle_ticks: got %0d want 3", n_tick); end
    n_vec++; if (n_urun != 3) begin n_bad++; $display("FAIL idle_underruns: got %0d want 3", n_urun); end
    n_vec++; if (tick_err != 0) begin n_bad++; $display("FAIL idle_tick_pos: got %0d errors want 0", tick_err); end
    n_vec++; if (ready_err != 0) begin n_bad++; $display("FAIL idle_ready: got %0d errors want 0", ready_err); end
  endtask

  task automatic test_pwm();
    int pos_err = 0;
    sample_data = {8'd192, 8'd64}; sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    n_vec++; if (sample_ready !== 1'b0) begin n_bad++; $display("FAIL pwm_ready_drop: got %b want 0", sample_ready); end
    run_to(FRAME-1);
    tick();
    n_vec++; if (underrun !== 1'b0) begin n_bad++; $display("FAIL pwm_no_underrun: got %b want 0", underrun); end
    n_vec++; if (frame_tick !== 1'b1) begin n_bad++; $display("FAIL pwm_tick: got %b want 1", frame_tick); end
    for (int i = 0; i < FRAME; i++) begin
      if (i == 10) begin sample_data = {8'd255, 8'd0}; sample_valid = 1'b1; end
      if (i == 11) sample_valid = 1'b0;
      tick();
      if (dac_out[0] !== (tb_cnt != 0 && tb_cnt - 1 < 64))  pos_err++;
      if (dac_out[1] !== (tb_cnt != 0 && tb_cnt - 1 < 192)) pos_err++;
    end
    n_vec++; if (pos_err != 0) begin n_bad++; $display("FAIL pwm_position: got %0d errors want 0", pos_err); end
    n_vec++; if (win_ones[0] != 64) begin n_bad++; $display("FAIL pwm_ch0_high: got %0d want 64", win_ones[0]); end
    n_vec++; if (win_ones[1] != 192) begin n_bad++; $display("FAIL pwm_ch1_high: got %0d want 192", win_ones[1]); end
    run_to(FRAME-1);
    tick();
    for (int c = 0; c < CH; c++) begin
      n_vec++;
      if (win_ones[c] != int'(win_exp[c])) begin
        n_bad++; $display("FAIL pwm_extremes ch%0d: got %0d want %0d", c, win_ones[c], win_exp[c]);
      end
    end
  endtask

  task automatic test_sd();
    int pos_err = 0;
    logic e0, e1;
    run_to(100);
    mode = 1'b1;
    sample_data = {8'd128, 8'd1}; sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    run_to(0);
    // Frames: SD (mode dropped mid-frame), PWM (mode raised mid-frame), SD again.
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < FRAME; i++) begin
        if (i == 128 && f == 0) mode = 1'b0;
        if (i == 128 && f == 1) mode = 1'b1;
        tick();
        if (f == 1) begin
          e0 = (tb_cnt != 0 && tb_cnt - 1 < 1);
          e1 = (tb_cnt != 0 && tb_cnt - 1 < 128);
        end else begin
          e0 = (tb_cnt == 0);
          e1 = (tb_cnt % 2 == 0);
        end
        if (dac_out[0] !== e0) pos_err++;
        if (dac_out[1] !== e1) pos_err++;
      end
      for (int c = 0; c < CH; c++) begin
        n_vec++;
        if (win_ones[c] != int'(win_exp[c])) begin
          n_bad++; $display("FAIL sd_frame%0d ch%0d: got %0d want %0d", f, c, win_ones[c], win_exp[c]);
        end
      end
    end
    n_vec++; if (pos_err != 0) begin n_bad++; $display("FAIL sd_pattern: got %0d errors want 0", pos_err); end
    n_vec++; if (urun_err != 0) begin n_bad++; $display("FAIL sd_underrun: got %0d errors want 0", urun_err); end
  endtask

  task automatic test_back_to_back();
    int acc0 = n_acc;
    int urun0 = n_urun;
    int rdy_err = 0;
    mode = 1'b0;
    sample_valid = 1'b1;
    for (int i = 0; i < 4*FRAME; i++) begin
      sample_data = 16'($urandom);
      tick();
      if (tb_cnt == 0 && sample_ready !== 1'b1) rdy_err++;
      if (tb_cnt == 1 && sample_ready !== 1'b0) rdy_err++;
      if (tb_cnt == 0) begin
        for (int c = 0; c < CH; c++) begin
          n_vec++;
          if (win_ones[c] != int'(win_exp[c])) begin
            n_bad++; $display("FAIL b2b_window ch%0d: got %0d want %0d", c, win_ones[c], win_exp[c]);
          end
        end
      end
    end
    sample_valid = 1'b0;
    n_vec++; if (n_acc - acc0 != 4) begin n_bad++; $display("FAIL b2b_accepts: got %0d want 4", n_acc - acc0); end
    n_vec++; if (n_urun - urun0 != 0) begin n_bad++; $display("FAIL b2b_underrun: got %0d want 0", n_urun - urun0); end
    n_vec++; if (rdy_err != 0) begin n_bad++; $display("FAIL b2b_ready: got %0d errors want 0", rdy_err); end
  endtask

  task automatic test_boundary_offer();
    run_to(FRAME-1);
    sample_data = {8'd77, 8'd33}; sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    n_vec++; if (underrun !== 1'b1) begin n_bad++; $display("FAIL bnd_underrun: got %b want 1", underrun); end
    n_vec++; if (sample_ready !== 1'b0) begin n_bad++; $display("FAIL bnd_ready: got %b want 0", sample_ready); end
    for (int f = 0; f < 2; f++) begin
      run_to(FRAME-1);
      tick();
      for (int c = 0; c < CH; c++) begin
        n_vec++;
        if (win_ones[c] != int'(win_exp[c])) begin
          n_bad++; $display("FAIL bnd_frame%0d ch%0d: got %0d want %0d", f, c, win_ones[c], win_exp[c]);
        end
      end
    end
    n_vec++; if (win_ones[0] != 33) begin n_bad++; $display("FAIL bnd_late_apply: got %0d want 33", win_ones[0]); end
  endtask

  task automatic test_reset_mid();
    sample_data = {8'd200, 8'd150}; sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    run_to(100);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_vec++; if (dac_out !== 2'b00) begin n_bad++; $display("FAIL rmid_dac: got %b want 00", dac_out); end
    n_vec++; if (sample_ready !== 1'b1) begin n_bad++; $display("FAIL rmid_ready: got %b want 1", sample_ready); end
    tick_err = 0; urun_err = 0; ready_err = 0;
    for (int i = 0; i < FRAME; i++) tick();
    n_vec++; if (win_ones[0] != 0 || win_ones[1] != 0) begin
      n_bad++; $display("FAIL rmid_active: got %0d/%0d want 0/0", win_ones[0], win_ones[1]);
    end
    n_vec++; if (tick_err != 0) begin n_bad++; $display("FAIL rmid_restart: got %0d errors want 0", tick_err); end
    n_vec++; if (urun_err != 0) begin n_bad++; $display("FAIL rmid_underrun: got %0d errors want 0", urun_err); end
    n_vec++; if (ready_err != 0) begin n_bad++; $display("FAIL rmid_ready_seq: got %0d errors want 0", ready_err); end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_idle();
    test_pwm();
    test_sd();
    test_back_to_back();
    test_boundary_offer();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
